// File: rtl/dnn_pkg.sv
// dnn_pkg: shared definitions for the DNN layer sequencer.
//   - default activation / MAC result widths
//   - FSM state encoding
//   - saturation bound helpers and default bound constants
package dnn_pkg;

  localparam int DNN_IN_SIZE  = 7;
  localparam int DNN_OUT_SIZE = 17;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_OUT   = 3'd3,
    ST_ABORT = 3'd4
  } dnn_state_e;

  // Largest value representable in a signed field of width w.
  function automatic int sat_max(input int w);
    return (32'sd1 <<< (w - 32'sd1)) - 32'sd1;
  endfunction

  // Smallest value representable in a signed field of width w.
  function automatic int sat_min(input int w);
    return -(32'sd1 <<< (w - 32'sd1));
  endfunction

  localparam int DNN_SAT_MAX = sat_max(DNN_IN_SIZE);
  localparam int DNN_SAT_MIN = sat_min(DNN_IN_SIZE);

endpackage

// File: rtl/dnn_requant.sv
// dnn_requant: single-lane requantizer (combinational).
//   y    : wide signed MAC result
//   last : 1 on the final layer (no ReLU, symmetric clip), 0 on hidden layers
//   q    : y >>> SHIFT, ReLU on hidden layers, saturated to IN_SIZE signed
module dnn_requant
  import dnn_pkg::*;
#(
  parameter int IN_SIZE  = DNN_IN_SIZE,
  parameter int OUT_SIZE = DNN_OUT_SIZE,
  parameter int SHIFT    = 5
) (
  input  logic signed [OUT_SIZE-1:0] y,
  input  logic                       last,
  output logic signed [IN_SIZE-1:0]  q
);

  localparam logic signed [OUT_SIZE-1:0] HI_Q = OUT_SIZE'(sat_max(IN_SIZE));
  localparam logic signed [OUT_SIZE-1:0] LO_Q = OUT_SIZE'(sat_min(IN_SIZE));

  logic signed [OUT_SIZE-1:0] shifted_s;
  logic                       neg_s;

  // Arithmetic shift floors toward negative infinity; no rounding term.
  assign shifted_s = y >>> SHIFT;
  assign neg_s     = shifted_s[OUT_SIZE-1];

  // ReLU on hidden layers, then clip into the narrow signed range.
  always_comb begin
    q = '0;
    if (shifted_s > HI_Q) begin
      q = HI_Q[IN_SIZE-1:0];
    end else if (neg_s && !last) begin
      q = '0;
    end else if (shifted_s < LO_Q) begin
      q = LO_Q[IN_SIZE-1:0];
    end else begin
      q = shifted_s[IN_SIZE-1:0];
    end
  end

endmodule

// File: rtl/dnn_seq_ctrl.sv
// dnn_seq_ctrl: runs one 4-lane activation vector through NUM_LAYERS passes
// of a shared 4x4 MAC datapath, requantizing between passes.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_rdy/in_vec    : input vector handshake (x0 in LSBs)
//   mac_start/mac_x/layer_sel : pass request to datapath + weight bank select
//   mac_done/mac_y            : datapath completion and 4 wide results
//   out_valid/out_ready/out_vec : result handshake
//   busy : not idle;  err : one-cycle pulse on MAC timeout abort
module dnn_seq_ctrl
  import dnn_pkg::*;
#(
  parameter int IN_SIZE    = DNN_IN_SIZE,
  parameter int OUT_SIZE   = DNN_OUT_SIZE,
  parameter int NUM_LAYERS = 3,
  parameter int SHIFT      = 5,
  parameter int TIMEOUT    = 15,
  parameter int LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_rdy,
  input  logic [4*IN_SIZE-1:0]    in_vec,
  output logic                    mac_start,
  output logic [4*IN_SIZE-1:0]    mac_x,
  output logic [LW-1:0]           layer_sel,
  input  logic                    mac_done,
  input  logic [4*OUT_SIZE-1:0]   mac_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*IN_SIZE-1:0]    out_vec,
  output logic                    busy,
  output logic                    err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_ISSUE = ST_ISSUE;
  localparam logic [2:0] S_WAIT  = ST_WAIT;
  localparam logic [2:0] S_OUT   = ST_OUT;
  localparam logic [2:0] S_ABORT = ST_ABORT;

  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam logic [CW-1:0] TO_LIMIT   = CW'(TIMEOUT);

  logic [2:0]           state_r, state_nxt_s;
  logic [4*IN_SIZE-1:0] act_r, act_nxt_s;
  logic [LW-1:0]        layer_r, layer_nxt_s;
  logic [CW-1:0]        cnt_r, cnt_nxt_s, cnt_inc_s;
  logic                 in_rdy_r, mac_start_r, out_valid_r, busy_r, err_r;
  logic                 last_s;
  logic [4*IN_SIZE-1:0] rq_vec_s;

  assign last_s    = (layer_r == LAST_LAYER);
  assign cnt_inc_s = cnt_r + CW'(1);

  // Four identical requantizer lanes share the current layer's last flag.
  for (genvar g = 0; g < 4; g++) begin : g_rq
    dnn_requant #(
      .IN_SIZE  (IN_SIZE),
      .OUT_SIZE (OUT_SIZE),
      .SHIFT    (SHIFT)
    ) u_rq (
      .y    (mac_y[g*OUT_SIZE +: OUT_SIZE]),
      .last (last_s),
      .q    (rq_vec_s[g*IN_SIZE +: IN_SIZE])
    );
  end

  // Next-state and datapath-register update logic.
  always_comb begin
    state_nxt_s = state_r;
    act_nxt_s   = act_r;
    layer_nxt_s = layer_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          act_nxt_s   = in_vec;
          layer_nxt_s = '0;
          state_nxt_s = S_ISSUE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_nxt_s   = '0;
        state_nxt_s = S_WAIT;
      end
      S_WAIT: begin
        if (mac_done) begin
          act_nxt_s = rq_vec_s;
          if (last_s) begin
            state_nxt_s = S_OUT;
          end else begin
            layer_nxt_s = layer_r + LW'(1);
            state_nxt_s = S_ISSUE;
          end
        end else begin
          cnt_nxt_s = cnt_inc_s;
          if (cnt_inc_s == TO_LIMIT) begin
            state_nxt_s = S_ABORT;
          end else begin
            state_nxt_s = S_WAIT;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_OUT;
        end
      end
      S_ABORT: begin
        act_nxt_s   = '0;
        state_nxt_s = S_IDLE;
      end
      default: begin
        act_nxt_s   = '0;
        layer_nxt_s = '0;
        cnt_nxt_s   = '0;
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State registers; handshake flags are decoded from the next state so
  // they are flops that line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      act_r       <= '0;
      layer_r     <= '0;
      cnt_r       <= '0;
      in_rdy_r    <= 1'b1;
      mac_start_r <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      act_r       <= act_nxt_s;
      layer_r     <= layer_nxt_s;
      cnt_r       <= cnt_nxt_s;
      in_rdy_r    <= (state_nxt_s == S_IDLE);
      mac_start_r <= (state_nxt_s == S_ISSUE);
      out_valid_r <= (state_nxt_s == S_OUT);
      busy_r      <= (state_nxt_s != S_IDLE);
      err_r       <= (state_nxt_s == S_ABORT);
    end
  end

  assign in_rdy    = in_rdy_r;
  assign mac_start = mac_start_r;
  assign mac_x     = act_r;
  assign layer_sel = layer_r;
  assign out_valid = out_valid_r;
  assign out_vec   = act_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule

// File: doc/dnn_seq_ctrl.md
# dnn_seq_ctrl

Sequencer that time-multiplexes the shared 4-input, 4-output MAC layer datapath across `NUM_LAYERS` fully-connected layers. It accepts one 4-lane activation vector and issues one MAC pass per layer, driving the layer index to the weight store. Between passes it requantizes the wide MAC results (shift, ReLU, saturate) back to input width. It returns the final vector over a valid/ready handshake and sits between the input feeder and the output consumer, wrapping the MAC datapath.

## Interface
Parameters:
- `IN_SIZE`, 7: activation/weight width, signed.
- `OUT_SIZE`, 17: MAC result width, signed.
- `NUM_LAYERS`, 3: layers per inference, at least 1.
- `SHIFT`, 5: arithmetic right shift applied in requantization.
- `TIMEOUT`, 15: maximum WAIT cycles before abort, at least 1.
- `LW`, `$clog2(NUM_LAYERS)`, minimum 1: layer index width.

Ports:
- `clk` in 1: single clock. All logic uses its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: input vector valid.
- `in_rdy` out 1: controller can accept a vector.
- `in_vec` in 4*IN_SIZE: lanes x0..x3, with x0 in the LSBs.
- `mac_start` out 1: one-cycle start pulse to the datapath's `in_ready`.
- `mac_x` out 4*IN_SIZE: current activations to the datapath.
- `layer_sel` out LW: weight bank select for the current layer.
- `mac_done` in 1: datapath `mac_ready`.
- `mac_y` in 4*OUT_SIZE: datapath out4..out7, with out4 in the LSBs.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_vec` out 4*IN_SIZE: final quantized vector.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: one-cycle pulse on timeout abort.

## Operation
The FSM has five states: IDLE, ISSUE, WAIT, OUT, ABORT.
- **IDLE**
  - `in_rdy`=1.
  - On `in_valid`: latch `in_vec` into the activation register `act`, clear `layer` to 0, go to ISSUE.
- **ISSUE**
  - `mac_start`=1 for exactly this cycle.
  - `mac_x`=`act` and `layer_sel`=`layer`; both are held stable from ISSUE through WAIT.
  - Clear the timeout counter, go to WAIT.
- **WAIT**
  - On `mac_done`: requantize all four lanes of `mac_y` into `act`.
    - If `layer`==NUM_LAYERS-1, go to OUT.
    - Otherwise increment `layer` and go to ISSUE.
  - If `mac_done` is low, increment the counter. If the counter reaches TIMEOUT, go to ABORT.
- **OUT**
  - `out_valid`=1 and `out_vec`=`act`. Both are held until `out_ready`.
  - Go to IDLE on the cycle `out_ready` is high.
- **ABORT**
  - `err`=1 for one cycle, `act` is cleared, go to IDLE.

Requantization, per lane:
- Compute `q = y >>> SHIFT`, signed, truncating toward negative infinity, with no rounding.
- Hidden layers (`layer` < NUM_LAYERS-1): ReLU, so q<0 gives 0. Then saturate to at most 2^(IN_SIZE-1)-1, which is 63.
- Last layer: no ReLU. Saturate to [-2^(IN_SIZE-1), 2^(IN_SIZE-1)-1], which is [-64, 63].

Other rules:
- `mac_done` is ignored in every state except WAIT.
- `in_valid` is ignored outside IDLE, because `in_rdy` is 0 there.

## Timing
- Reset values:
  - State IDLE.
  - `in_rdy`=1.
  - `mac_start`=0, `out_valid`=0, `busy`=0, `err`=0.
  - `layer`=0, `act`=0, so `mac_x`, `layer_sel` and `out_vec` are all 0.
- Assumed datapath latency is 1: `mac_done` is high in the cycle after `mac_start`. Each layer then costs 2 cycles (ISSUE, WAIT).
- Vector accepted in cycle k gives `out_valid` high first in cycle k+1+2·NUM_LAYERS. With defaults this is k+7.
- The earliest next accept is the cycle after the `out_valid`&`out_ready` handshake. There is no input/output overlap.
- Reset asserted mid-inference:
  - At the next edge, all registers return to their reset values.
  - A late `mac_done` after reset is ignored.
  - No `err` pulse is produced.
- Timeout: with `mac_done` never arriving, ABORT is entered after TIMEOUT WAIT cycles and `err` pulses in the next cycle.

## Structure
- Package `dnn_pkg` holds:
  - Default `IN_SIZE` and `OUT_SIZE`.
  - The FSM state enum.
  - Saturation bound constants.
- Sub-module `dnn_requant`: combinational, one lane, with a `last` input. It is instantiated 4× inside `dnn_seq_ctrl`.

## Test plan
- **Basic inference:** defaults, 1-cycle MAC model, `mac_y` lanes {96, 0, -32, 31}, `out_ready`=1.
  - Expect `layer_sel` 0,1,2 across three ISSUE pulses.
  - Expect final `out_vec` {3, 0, -1, 0}, with `out_valid` in cycle k+7.
- **Saturation and ReLU:** `mac_y`=2048 on a hidden layer gives 63; `mac_y`=-100 on a hidden layer gives 0.
  - On the last layer, -100 gives -4 and -4096 gives -64.
- **Backpressure:** hold `out_ready`=0 for 5 cycles.
  - Expect `out_valid` and `out_vec` stable throughout, and `in_rdy`=0 with `in_valid` ignored.
  - Release: return to IDLE and accept the next vector in the following cycle.
- **Timeout:** suppress `mac_done` during layer 1.
  - Expect exactly one `err` pulse after 15 WAIT cycles, then `act`=0, IDLE, and `in_rdy`=1.
- **Reset mid-operation:** drop `rst_n` in the WAIT state of layer 1, with `mac_done` arriving 1 cycle after reset.
  - Expect all outputs at reset values, no state change, and `err`=0.
- **Spurious `mac_done`:** pulse `mac_done` during IDLE and OUT.
  - Expect no change to state, `act`, or `layer`.
